tristate_bus_arbiter: RTL

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

---
 rtl/tristate_arb_pkg.sv | 19 +
 rtl/rr_picker.sv | 33 +++
 rtl/tristate_bus_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tristate_arb_pkg.sv
// Shared types and constants for the tri-state bus arbiter.
// Holds the FSM state enum, default sizing and the owner-index width helper.
package tristate_arb_pkg;

    localparam int unsigned DefaultNReq    = 4;
    localparam int unsigned DefaultMaxHold = 8;

    typedef enum logic [1:0] {
        StIdle,
        StOwn,
        StTurn
    } arb_state_e;

    // Width of an owner index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first asserted request strictly
// after last_owner, searching upward with wrap-around.
module rr_picker
    import tristate_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DefaultNReq,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        logic [IDX_W:0] cand;
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            // One spare bit keeps last_owner + i from overflowing before the wrap.
            cand = {1'b0, last_owner} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(N_REQ)) begin
                cand = cand - (IDX_W + 1)'(N_REQ);
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                index = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus with a one-cycle
// turnaround between owners. Define ARB_TIMEOUT_EN to bound tenure to MAX_HOLD cycles.
module tristate_bus_arbiter
    import tristate_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = DefaultNReq,
    parameter int unsigned MAX_HOLD = DefaultMaxHold
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req,
    output logic [N_REQ-1:0]               oe,
    output logic [idx_width(N_REQ)-1:0]    sel,
    output logic                           busy,
    output logic                           preempt
);

    localparam int unsigned IdxW = idx_width(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("N_REQ must be in 2..8");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] oe_q, oe_d;
    logic [IdxW-1:0]  sel_q, sel_d;
    logic [IdxW-1:0]  last_q, last_d;
    logic             busy_q, busy_d;

    logic             pick_valid;
    logic [IdxW-1:0]  pick_idx;
    logic             owner_req;
    logic             hold_expired;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IdxW)
    ) u_picker (
        .req        (req),
        .last_owner (last_q),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    assign owner_req = req[sel_q];

    always_comb begin
        state_d = state_q;
        oe_d    = oe_q;
        sel_d   = sel_q;
        last_d  = last_q;
        busy_d  = busy_q;
        unique case (state_q)
            StIdle, StTurn: begin
                // Turnaround and idle arbitrate identically; TURN only guarantees the gap.
                if (pick_valid) begin
                    state_d        = StOwn;
                    oe_d           = '0;
                    oe_d[pick_idx] = 1'b1;
                    sel_d          = pick_idx;
                    last_d         = pick_idx;
                    busy_d         = 1'b1;
                end else begin
                    state_d = StIdle;
                    oe_d    = '0;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            StOwn: begin
                if (!owner_req || hold_expired) begin
                    state_d = StTurn;
                    oe_d    = '0;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                oe_d    = '0;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            oe_q    <= '0;
            sel_q   <= '0;
            last_q  <= IdxW'(N_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            oe_q    <= oe_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       preempt_q, preempt_d;

    // oe_q is one-hot in OWN, so masking it leaves only competing requesters.
    assign hold_expired = (hold_q == 8'(MAX_HOLD)) && (|(req & ~oe_q));

    always_comb begin
        hold_d = '0;
        if (state_d == StOwn) begin
            if (state_q != StOwn) begin
                hold_d = 8'd1;
            end else if (hold_q == 8'(MAX_HOLD)) begin
                hold_d = hold_q;
            end else begin
                hold_d = hold_q + 8'd1;
            end
        end
        preempt_d = (state_q == StOwn) && owner_req && hold_expired;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    assign hold_expired = 1'b0;
    assign preempt      = 1'b0;
`endif

    assign oe   = oe_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule
